word_streamer: RTL and testbench
================================

WORD_STREAMER -- requirements
Module: word_streamer

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning memory word width in bits.
REQ-002 SHALL have parameter CHUNK_W, default 8, meaning output chunk width in bits; WORD_W SHALL be an integer multiple of CHUNK_W, and NCHUNK = WORD_W/CHUNK_W.
REQ-003 SHALL have parameter ADDR_W, default 5, meaning memory address width.
REQ-004 SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a transfer.
- base_addr  input  ADDR_W  first word address, sampled on accepted start.
- word_count  input  ADDR_W+1  number of words to stream, sampled on accepted start.
- msb_first  input  1  chunk order, sampled on accepted start: 1 = top chunk first, 0 = bottom chunk first.
- mem_rd_en  output  1  memory read strobe.
- mem_addr  output  ADDR_W  memory read address.
- mem_rdata  input  WORD_W  read data, valid exactly one cycle after mem_rd_en.
- out_data  output  CHUNK_W  current chunk.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  sink accepts the chunk when out_valid and out_ready are both high.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a transfer completes.

Function
REQ-005 SHALL implement the states IDLE, READ, LOAD, SEND and FINISH.
REQ-006 IDLE: start=1 SHALL be accepted; base_addr, word_count and msb_first SHALL be latched.
- If word_count!=0, the next state SHALL be READ.
- If word_count==0, the next state SHALL be FINISH, with no memory read and no output.
REQ-007 READ: mem_rd_en SHALL be 1 for exactly one cycle, with mem_addr equal to the current address; the next state SHALL be LOAD.
REQ-008 LOAD: mem_rdata SHALL be captured into a WORD_W shift register and the chunk index SHALL be cleared; the next state SHALL be SEND.
REQ-009 SEND: out_valid SHALL be 1.
- When msb_first=1, out_data SHALL be the top CHUNK_W bits of the shift register.
- When msb_first=0, out_data SHALL be the bottom CHUNK_W bits of the shift register.
REQ-010 SEND with out_valid=1 and out_ready=0: out_data SHALL be held stable and the state SHALL not change.
REQ-011 SEND with a handshake: the shift register SHALL shift by CHUNK_W toward the output end and the chunk index SHALL increment.
- On a handshake of chunk NCHUNK-1 with words remaining, the address SHALL increment, the remaining-word count SHALL decrement, and the next state SHALL be READ.
- On a handshake of chunk NCHUNK-1 of the last word, the next state SHALL be FINISH.
REQ-012 The address SHALL wrap modulo 2^ADDR_W; for example, with ADDR_W=5, address 31 increments to 0.
REQ-013 FINISH: done SHALL be 1 for exactly one cycle and the next state SHALL be IDLE; done SHALL be 0 in every other cycle.
REQ-014 start SHALL be ignored in every state other than IDLE, including the FINISH cycle.
REQ-015 Per-word latency: from READ entry to first out_valid SHALL be 2 cycles. At out_ready=1, a word SHALL take NCHUNK+2 cycles in total.
REQ-016 mem_rd_en SHALL be 0 outside READ, and out_valid SHALL be 0 outside SEND.
REQ-017 mem_addr SHALL hold its last value whenever mem_rd_en=0.

Reset
REQ-018 rst=1 at a rising edge SHALL force IDLE in any state, including mid-SEND; the transfer SHALL be abandoned and no done pulse SHALL be generated.
REQ-019 After reset the following SHALL be 0: mem_rd_en, mem_addr, out_data, out_valid, busy, done, the shift register, the chunk index and the remaining-word count.
REQ-020 A start coincident with rst=1 SHALL be ignored.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Basic: defaults; mem[3]=0xA1B2C3D4; start, base_addr=3, word_count=1, msb_first=1, out_ready=1 -> chunks A1, B2, C3, D4 on consecutive cycles, then done for one cycle, busy=0.
- Order: same setup with msb_first=0 -> chunks D4, C3, B2, A1.
- Backpressure and wrap: base_addr=31, word_count=2; mem[31]=0x11223344, mem[0]=0x55667788; out_ready toggling 1,0,1,0 -> mem_addr sequence 31 then 0; 8 chunks 11..88 each held stable while out_ready=0; no chunk dropped or duplicated.
- Zero length: word_count=0 -> done on the cycle after start; mem_rd_en and out_valid never asserted.
- Reset mid-transfer and ignored start: rst pulsed after the second chunk of a 4-word transfer -> next cycle all outputs 0, no done; a start pulse during SEND of another transfer is ignored and that transfer's output is unchanged.
- Parameter variant: WORD_W=16, CHUNK_W=4, mem[0]=0xBEEF, msb_first=1 -> chunks B, E, E, F.

Source files
------------

// File: rtl/word_streamer.sv
// Streams memory words out as CHUNK_W-wide chunks over a valid/ready handshake.
// One read per word, then the word is shifted out chunk by chunk in the latched order.
module word_streamer #(
  parameter int WORD_W  = 32,
  parameter int CHUNK_W = 8,
  parameter int ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W:0]    word_count,
  input  logic               msb_first,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [WORD_W-1:0]  mem_rdata,
  output logic [CHUNK_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  localparam int NCHUNK = WORD_W / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [ADDR_W:0]   ONE_WORD = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {IDLE, READ, LOAD, SEND, FINISH} state_t;

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, mem_addr_q;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                msb_q, msb_d;

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    rem_d   = rem_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    msb_d   = msb_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          rem_d   = word_count;
          msb_d   = msb_first;
          state_d = (word_count != '0) ? READ : FINISH;
        end
      end
      READ: state_d = LOAD;
      LOAD: begin
        shreg_d = mem_rdata;
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
          shreg_d = msb_q ? (shreg_q << CHUNK_W) : (shreg_q >> CHUNK_W);
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            if (rem_q > ONE_WORD) begin
              addr_d  = addr_q + 1'b1;
              rem_d   = rem_q - 1'b1;
              state_d = READ;
            end else begin
              state_d = FINISH;
            end
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mem_addr only moves on entry to READ so it stays put between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      rem_q      <= '0;
      shreg_q    <= '0;
      idx_q      <= '0;
      msb_q      <= 1'b0;
    end else begin
      state   <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      msb_q   <= msb_d;
      if (state_d == READ) mem_addr_q <= addr_d;
    end
  end

  assign mem_rd_en = (state == READ);
  assign mem_addr  = mem_addr_q;
  assign out_valid = (state == SEND);
  assign out_data  = msb_q ? shreg_q[WORD_W-1 -: CHUNK_W] : shreg_q[CHUNK_W-1:0];
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

endmodule

// File: tb/tb_word_streamer.sv
// Scoreboard bench for word_streamer: default 32/8 instance plus a 16/4 instance.
module tb_word_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  base_addr = '0;
  logic [5:0]  word_count = '0;
  logic        msb_first = 1'b0;
  logic        mem_rd_en;
  logic [4:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done;

  logic        start16 = 1'b0;
  logic [4:0]  base16 = '0;
  logic [5:0]  wc16 = '0;
  logic        msb16 = 1'b1;
  logic        rd16;
  logic [4:0]  addr16;
  logic [15:0] rdata16 = '0;
  logic [3:0]  od16;
  logic        ov16;
  logic        ready16 = 1'b1;
  logic        busy16, done16;

  logic [31:0] mem   [32];
  logic [15:0] mem16 [32];

  logic [7:0]  exp_q[$];
  logic [4:0]  exp_addr_q[$];
  logic [3:0]  exp16_q[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0, hs_cnt = 0, rd_cnt = 0, vld_cnt = 0;
  logic ready_toggle = 1'b0;

  word_streamer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .msb_first(msb_first), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  word_streamer #(.WORD_W(16), .CHUNK_W(4), .ADDR_W(5)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .base_addr(base16),
    .word_count(wc16), .msb_first(msb16), .mem_rd_en(rd16),
    .mem_addr(addr16), .mem_rdata(rdata16), .out_data(od16),
    .out_valid(ov16), .out_ready(ready16), .busy(busy16), .done(done16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (rd16) rdata16 <= mem16[addr16];
  end

  always @(posedge clk) begin
    #1;
    out_ready = ready_toggle ? ~out_ready : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic       hold_pend = 1'b0;
  logic [7:0] held = '0;
  logic [4:0] prev_addr = '0;
  logic       rst_seen = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
      rst_seen  = 1'b1;
    end else begin
      if (hold_pend) begin
        check("hold_valid", {31'b0, out_valid}, 32'd1);
        check("hold_data", {24'b0, out_data}, {24'b0, held});
      end
      if (out_valid) vld_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("extra_chunk", {31'b0, out_valid}, 32'd0);
        else check("chunk", {24'b0, out_data}, {24'b0, exp_q.pop_front()});
      end
      if (mem_rd_en) begin
        rd_cnt++;
        check("rd_vs_valid", {31'b0, out_valid}, 32'd0);
        if (exp_addr_q.size() == 0) check("extra_rd", {31'b0, mem_rd_en}, 32'd0);
        else check("rd_addr", {27'b0, mem_addr}, {27'b0, exp_addr_q.pop_front()});
      end else if (!rst_seen) begin
        check("addr_hold", {27'b0, mem_addr}, {27'b0, prev_addr});
      end
      if (done) done_cnt++;
      hold_pend = out_valid && !out_ready;
      held      = out_data;
      prev_addr = mem_addr;
      rst_seen  = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && ov16) begin
      if (exp16_q.size() == 0) check("extra_chunk16", {31'b0, ov16}, 32'd0);
      else check("chunk16", {28'b0, od16}, {28'b0, exp16_q.pop_front()});
    end
  end

  task automatic do_start(input logic [4:0] ba, input logic [5:0] wc, input logic msb);
    logic [31:0] w;
    for (int unsigned k = 0; k < 32'(wc); k++) begin
      exp_addr_q.push_back(5'(32'(ba) + k));
      w = mem[5'(32'(ba) + k)];
      for (int unsigned c = 0; c < 4; c++)
        exp_q.push_back(msb ? w[31 - 8*c -: 8] : w[8*c +: 8]);
    end
    base_addr = ba; word_count = wc; msb_first = msb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic finish_xfer(input int d0);
    @(posedge clk); #1;
    check("done_pulse", {31'b0, done}, 32'd0);
    check("busy_after", {31'b0, busy}, 32'd0);
    check("done_count", done_cnt, d0 + 1);
    check("chunks_left", exp_q.size(), 32'd0);
    check("reads_left", exp_addr_q.size(), 32'd0);
  endtask

  initial begin
    int n, d0, r0, v0, h0;
    for (int i = 0; i < 32; i++) begin
      mem[i]   = $urandom;
      mem16[i] = 16'($urandom);
    end
    mem[3]   = 32'hA1B2C3D4;
    mem[31]  = 32'h11223344;
    mem[0]   = 32'h55667788;
    mem16[0] = 16'hBEEF;

    // reset with a coincident start that must be ignored
    rst = 1'b1; start = 1'b1; word_count = 6'd1; base_addr = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
    check("rst_addr", {27'b0, mem_addr}, 32'd0);
    check("rst_data", {24'b0, out_data}, 32'd0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    check("rst_start_ignored", {31'b0, busy}, 32'd0);

    // basic, msb first
    d0 = done_cnt;
    do_start(5'd3, 6'd1, 1'b1);
    check("basic_rd_en", {31'b0, mem_rd_en}, 32'd1);
    check("basic_busy", {31'b0, busy}, 32'd1);
    wait_done(50, n);
    check("basic_latency", n, 32'd6);
    finish_xfer(d0);

    // order, lsb first
    d0 = done_cnt;
    do_start(5'd3, 6'd1, 1'b0);
    wait_done(50, n);
    check("order_latency", n, 32'd6);
    finish_xfer(d0);

    // backpressure and address wrap
    d0 = done_cnt;
    ready_toggle = 1'b1;
    do_start(5'd31, 6'd2, 1'b1);
    wait_done(100, n);
    ready_toggle = 1'b0;
    finish_xfer(d0);

    // zero length, start held into FINISH must not retrigger
    d0 = done_cnt; r0 = rd_cnt; v0 = vld_cnt;
    base_addr = 5'd7; word_count = 6'd0; msb_first = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("zero_done", {31'b0, done}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done_once", {31'b0, done}, 32'd0);
    check("zero_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("zero_done_count", done_cnt, d0 + 1);
    check("zero_no_read", rd_cnt, r0);
    check("zero_no_valid", vld_cnt, v0);

    // reset after the second chunk of a 4-word transfer
    d0 = done_cnt; h0 = hs_cnt;
    do_start(5'd28, 6'd4, 1'b1);
    n = 0;
    while (hs_cnt < h0 + 2 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("mid_hs_reached", hs_cnt, h0 + 2);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rd_en", {31'b0, mem_rd_en}, 32'd0);
    check("mid_addr", {27'b0, mem_addr}, 32'd0);
    check("mid_data", {24'b0, out_data}, 32'd0);
    check("mid_valid", {31'b0, out_valid}, 32'd0);
    check("mid_busy", {31'b0, busy}, 32'd0);
    check("mid_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("mid_no_done", done_cnt, d0);
    check("mid_idle", {31'b0, busy}, 32'd0);

    // start pulse during SEND is ignored
    d0 = done_cnt;
    do_start(5'd10, 6'd2, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ign_in_send", {31'b0, out_valid}, 32'd1);
    base_addr = 5'd20; word_count = 6'd3; msb_first = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50, n);
    finish_xfer(d0);

    // 16/4 variant
    exp16_q.push_back(4'hB); exp16_q.push_back(4'hE);
    exp16_q.push_back(4'hE); exp16_q.push_back(4'hF);
    base16 = 5'd0; wc16 = 6'd1; msb16 = 1'b1; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("p16_done", {31'b0, done16}, 32'd1);
    check("p16_latency", n, 32'd6);
    @(posedge clk); #1;
    check("p16_chunks_left", exp16_q.size(), 32'd0);
    check("p16_busy", {31'b0, busy16}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
